// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Central stall/flush controller for the 5-stage ARM pipeline (IF, ID, EXE,
// MEM, WB). It sits beside the ID stage and arbitrates three stall/flush
// sources: RAW data hazards, taken branches resolved in EXE, and multi-cycle
// data-memory accesses. Memory accesses are guarded by a timeout watchdog.
//
// Parameters:
//   MEM_TIMEOUT   consecutive unserved memory-request cycles before the error
//                 state is entered (legal 2..255)
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   id_src1/id_src2          ID source registers (Rn, Rm or store Rd)
//   id_two_src, id_valid     id_src2 is a real operand / ID holds an instruction
//   exe_dest, exe_wb_en      EXE destination and write-back enable
//   mem_dest, mem_wb_en      MEM destination and write-back enable
//   branch_taken             EXE branch resolved taken
//   mem_req, mem_ready       MEM stage access request / access completes
//   freeze_pc, freeze_if_id  hold PC / hold IF/ID (combinational)
//   bubble_id_ex             load NOP into ID/EXE (combinational)
//   flush_if_id              load NOP into IF/ID (combinational)
//   freeze_all               hold every pipeline register (combinational)
//   mem_err                  sticky memory timeout flag (registered)
//   state                    current FSM state, for debug
//   stall_cnt, flush_cnt,
//   wait_cnt_total           saturating performance counters
//
// Build option:
//   PIPE_PERF_CNT_EN  when defined, the performance counters are built;
//                     otherwise the counter ports are tied to zero.
module pipeline_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_valid,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        freeze_pc,
  output logic        freeze_if_id,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic        freeze_all,
  output logic        mem_err,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] wait_cnt_total
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2,
    ILLEGAL  = 2'd3
  } seqState_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  seqState_t  state_q, state_d;
  logic [7:0] tmoCnt_q, tmoCnt_d;
  logic       memErr_q, memErr_d;
  logic       haz;
  logic       memBlock;
  logic       tmoHit;
  logic       applyRules;

  // RAW hazard detection between ID sources and the EXE/MEM producers.
  // Without forwarding, any match against a writing producer must stall.
  always_comb begin
    haz = id_valid &
          ((exe_wb_en & (id_src1 == exe_dest)) |
           (mem_wb_en & (id_src1 == mem_dest)) |
           (id_two_src & ((exe_wb_en & (id_src2 == exe_dest)) |
                          (mem_wb_en & (id_src2 == mem_dest)))));
    memBlock = mem_req & ~mem_ready;
    tmoHit   = (tmoCnt_q == TMO_LAST) & ~mem_ready;
  end

  // Next-state and Mealy control logic. The branch/hazard rules are shared
  // between a normal RUN cycle and the release cycle of MEM_WAIT, so they are
  // applied after the state decode through the applyRules flag. Reset forces
  // every combinational control low regardless of state.
  always_comb begin
    state_d      = state_q;
    tmoCnt_d     = tmoCnt_q;
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    freeze_all   = 1'b0;
    applyRules   = 1'b0;

    case (state_q)
      RUN: begin
        if (memBlock) begin
          freeze_all = 1'b1;
          tmoCnt_d   = tmoCnt_q + 8'd1;
          state_d    = tmoHit ? ERR : MEM_WAIT;
        end else begin
          tmoCnt_d   = 8'd0;
          applyRules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_req) begin
          // Requester abandoned the access: give the pipeline back.
          state_d  = RUN;
          tmoCnt_d = 8'd0;
        end else if (!mem_ready) begin
          freeze_all = 1'b1;
          tmoCnt_d   = tmoCnt_q + 8'd1;
          state_d    = tmoHit ? ERR : MEM_WAIT;
        end else begin
          state_d    = RUN;
          tmoCnt_d   = 8'd0;
          applyRules = 1'b1;
        end
      end
      ERR: begin
        freeze_all = 1'b1;
      end
      default: begin
        state_d  = RUN;
        tmoCnt_d = 8'd0;
      end
    endcase

    if (applyRules) begin
      if (branch_taken) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (haz) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        bubble_id_ex = 1'b1;
      end
    end

    if (!rst) begin
      freeze_pc    = 1'b0;
      freeze_if_id = 1'b0;
      bubble_id_ex = 1'b0;
      flush_if_id  = 1'b0;
      freeze_all   = 1'b0;
    end

    memErr_d = memErr_q | (state_d == ERR);
  end

  // State, watchdog count and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      tmoCnt_q <= 8'd0;
      memErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmoCnt_q <= tmoCnt_d;
      memErr_q <= memErr_d;
    end
  end

  assign state   = state_q;
  assign mem_err = memErr_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stallCnt_q, flushCnt_q, waitCnt_q;
  logic        waitEvent;

  assign waitEvent = freeze_all & ((state_q == RUN) | (state_q == MEM_WAIT));

  // Saturating performance counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCnt_q <= 32'd0;
      flushCnt_q <= 32'd0;
      waitCnt_q  <= 32'd0;
    end else begin
      if (freeze_pc && stallCnt_q != 32'hFFFF_FFFF)
        stallCnt_q <= stallCnt_q + 32'd1;
      if (flush_if_id && flushCnt_q != 32'hFFFF_FFFF)
        flushCnt_q <= flushCnt_q + 32'd1;
      if (waitEvent && waitCnt_q != 32'hFFFF_FFFF)
        waitCnt_q <= waitCnt_q + 32'd1;
    end
  end

  assign stall_cnt      = stallCnt_q;
  assign flush_cnt      = flushCnt_q;
  assign wait_cnt_total = waitCnt_q;
`else
  assign stall_cnt      = 32'h0;
  assign flush_cnt      = 32'h0;
  assign wait_cnt_total = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Testbench for pipeline_sequencer: table-driven checks of the RUN-state
// branch/hazard rules plus hand-written multi-cycle sequences for memory
// wait, timeout, and reset from MEM_WAIT and ERR.
module tb_pipeline_sequencer;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        id_two_src, id_valid, exe_wb_en, mem_wb_en;
  logic        branch_taken, mem_req, mem_ready;
  logic        freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_all;
  logic        mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt_total;
  logic [4:0]  ctrl;

  int checks = 0;
  int errors = 0;
  int expStall = 0;
  int expFlush = 0;
  int expWait  = 0;

  typedef struct {
    logic [3:0] src1;
    logic [3:0] src2;
    logic       twoSrc;
    logic       valid;
    logic [3:0] exeDest;
    logic       exeWb;
    logic [3:0] memDest;
    logic       memWb;
    logic       branch;
    logic       memReq;
    logic       memReady;
    logic [4:0] expCtrl;
  } vec_t;

  vec_t tbl[13];

  pipeline_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .freeze_all(freeze_all), .mem_err(mem_err), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt_total(wait_cnt_total)
  );

  assign ctrl = {freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_all};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_valid = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; mem_dest = 4'd0; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    id_src1 = v.src1; id_src2 = v.src2; id_two_src = v.twoSrc; id_valid = v.valid;
    exe_dest = v.exeDest; exe_wb_en = v.exeWb; mem_dest = v.memDest; mem_wb_en = v.memWb;
    branch_taken = v.branch; mem_req = v.memReq; mem_ready = v.memReady;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " stall_cnt"}, stall_cnt, PERF_EN ? 32'(expStall) : 32'd0);
    checkOutput({tag, " flush_cnt"}, flush_cnt, PERF_EN ? 32'(expFlush) : 32'd0);
    checkOutput({tag, " wait_cnt"}, wait_cnt_total, PERF_EN ? 32'(expWait) : 32'd0);
  endtask

  initial begin
    // src1 src2 two valid exeD exeWb memD memWb br req rdy  {fpc,fifid,bub,flush,fall}
    tbl[0]  = '{4'd3, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100};
    tbl[2]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[3]  = '{4'd5, 4'd1, 1'b0, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11100};
    tbl[4]  = '{4'd1, 4'd7, 1'b0, 1'b1, 4'd7, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[5]  = '{4'd1, 4'd7, 1'b1, 1'b1, 4'd7, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100};
    tbl[6]  = '{4'd1, 4'd9, 1'b1, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11100};
    tbl[7]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00110};
    tbl[8]  = '{4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00110};
    tbl[9]  = '{4'd1, 4'd2, 1'b0, 1'b0, 4'd4, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00110};
    tbl[10] = '{4'd6, 4'd0, 1'b0, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11100};
    tbl[11] = '{4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100};
    tbl[12] = '{4'd4, 4'd8, 1'b1, 1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};

    // Reset with a live hazard on the inputs: controls must stay low.
    rst = 1'b0;
    idle();
    id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; branch_taken = 1'b1;
    tick();
    tick();
    checkOutput("reset ctrl", 32'(ctrl), 32'd0);
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset mem_err", 32'(mem_err), 32'd0);
    checkCounters("reset");
    idle();
    rst = 1'b1;
    tick();

    // Table of single-cycle RUN-state vectors.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(tbl[i].expCtrl));
      if (tbl[i].expCtrl[4]) expStall++;
      if (tbl[i].expCtrl[1]) expFlush++;
      if (tbl[i].expCtrl[0]) expWait++;
      tick();
      checkOutput($sformatf("vec%0d state", i), 32'(state), 32'd0);
      checkCounters($sformatf("vec%0d", i));
    end
    idle();
    tick();

    // Memory access served 4 cycles after request: 4 freeze cycles.
    mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("memwait c%0d freeze_all", c), 32'(freeze_all), 32'd1);
      checkOutput($sformatf("memwait c%0d state", c), 32'(state), (c == 0) ? 32'd0 : 32'd1);
      expWait++;
      tick();
    end
    mem_ready = 1'b1;
    branch_taken = 1'b1;
    #1;
    checkOutput("memwait release ctrl", 32'(ctrl), 32'b00110);
    checkOutput("memwait release state", 32'(state), 32'd1);
    expFlush++;
    tick();
    idle();
    checkOutput("memwait after state", 32'(state), 32'd0);
    checkCounters("memwait");

    // Access never served: ERR from cycle TMO onward, sticky until reset.
    mem_req = 1'b1;
    for (int c = 0; c < TMO + 4; c++) begin
      #1;
      checkOutput($sformatf("tmo c%0d freeze_all", c), 32'(freeze_all), 32'd1);
      checkOutput($sformatf("tmo c%0d state", c), 32'(state),
                  (c >= TMO) ? 32'd2 : ((c == 0) ? 32'd0 : 32'd1));
      checkOutput($sformatf("tmo c%0d mem_err", c), 32'(mem_err), (c >= TMO) ? 32'd1 : 32'd0);
      if (c < TMO) expWait++;
      tick();
    end
    checkCounters("tmo");
    mem_req = 1'b0;
    mem_ready = 1'b1;
    #1;
    checkOutput("err hold freeze_all", 32'(freeze_all), 32'd1);
    tick();
    checkOutput("err hold state", 32'(state), 32'd2);
    idle();
    rst = 1'b0;
    #1;
    checkOutput("err reset forced ctrl", 32'(ctrl), 32'd0);
    tick();
    rst = 1'b1;
    expStall = 0; expFlush = 0; expWait = 0;
    #1;
    checkOutput("err reset state", 32'(state), 32'd0);
    checkOutput("err reset mem_err", 32'(mem_err), 32'd0);
    checkOutput("err reset ctrl", 32'(ctrl), 32'd0);
    checkCounters("err reset");
    tick();

    // Reset in the middle of MEM_WAIT.
    mem_req = 1'b1;
    tick();
    tick();
    checkOutput("mw reset pre state", 32'(state), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("mw reset forced freeze_all", 32'(freeze_all), 32'd0);
    tick();
    rst = 1'b1;
    mem_req = 1'b0;
    #1;
    checkOutput("mw reset state", 32'(state), 32'd0);
    checkOutput("mw reset ctrl", 32'(ctrl), 32'd0);
    checkCounters("mw reset");
    tick();

    // Single hazard cycle then branch-with-hazard: counters step by one each.
    id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1;
    checkOutput("haz ctrl", 32'(ctrl), 32'b11100);
    expStall++;
    tick();
    checkCounters("haz");
    branch_taken = 1'b1;
    #1;
    checkOutput("br haz ctrl", 32'(ctrl), 32'b00110);
    expFlush++;
    tick();
    checkCounters("br haz");
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
